// File: rtl/spm_pkg.sv
// Shared state encoding and operand-length clamp for the SPM sequencing controller.
package spm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } spm_state_e;

    // A zero or oversized length selects the full operand width.
    function automatic int unsigned spm_clamp_len(input int unsigned len, input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/spm_shift_counter.sv
// Shift-cycle up-counter with synchronous clear/enable and terminal compare at 2*len-1.
module spm_shift_counter #(
    parameter int unsigned LEN_W = 6,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [LEN_W-1:0] i_len,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;
    logic [LEN_W:0]   w_last_full;
    logic [CNT_W-1:0] w_last;

    // len >= 1 always, so 2*len-1 never underflows and fits in CNT_W bits.
    assign w_last_full = {i_len, 1'b0} - (LEN_W+1)'(1);
    assign w_last      = CNT_W'(w_last_full);
    assign o_tc        = (r_count == w_last);
    assign o_count     = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencing controller for the serial-parallel multiplier: command accept, 2*Leff
// shift cycles, product capture and result handshake, with synchronous abort.
module spm_seq_ctrl
    import spm_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEN_W = $clog2(WIDTH + 1),
    parameter int unsigned CNT_W = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN_W-1:0] op_len,
    input  logic             abort,
    output logic             ld,
    output logic             clr,
    output logic             shift,
    output logic             cap,
    output logic [CNT_W-1:0] bit_idx,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready
);

    spm_state_e       r_state;
    spm_state_e       w_next;
    logic [LEN_W-1:0] r_leff;
    logic [CNT_W-1:0] w_cnt;
    logic             w_tc;
    logic             w_accept;
    logic             w_cnt_clr;
    logic             w_cnt_en;

    assign w_accept  = (r_state == S_IDLE) && in_valid && !abort;
    assign w_cnt_clr = (r_state == S_LOAD);
    // Holding at the terminal value keeps the counter from ever wrapping.
    assign w_cnt_en  = (r_state == S_MUL) && !w_tc && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_leff <= LEN_W'(WIDTH);
        end else if (w_accept) begin
            r_leff <= LEN_W'(spm_clamp_len(32'(op_len), WIDTH));
        end
    end

    spm_shift_counter #(
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_len   (r_leff),
        .o_count (w_cnt),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = S_LOAD;
            S_LOAD: w_next = abort ? S_IDLE : S_MUL;
            S_MUL:  begin
                if (abort)     w_next = S_IDLE;
                else if (w_tc) w_next = S_DONE;
            end
            S_DONE: if (abort || out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE) && !abort;
        ld        = (r_state == S_LOAD) && !abort;
        clr       = (r_state == S_LOAD) && !abort;
        shift     = (r_state == S_MUL) && !abort;
        cap       = (r_state == S_MUL) && w_tc && !abort;
        out_valid = (r_state == S_DONE) && !abort;
        busy      = (r_state == S_LOAD) || (r_state == S_MUL);
        bit_idx   = (r_state == S_MUL) ? w_cnt : '0;
    end

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Directed bench for spm_seq_ctrl at WIDTH=8: table-driven operations plus abort/reset corners.
module tb_spm_seq_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [LEN_W-1:0] op_len;
    logic             abort;
    logic             ld, clr, shift, cap, busy, out_valid;
    logic [CNT_W-1:0] bit_idx;
    logic             out_ready;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    spm_seq_ctrl #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_len    (op_len),
        .abort     (abort),
        .ld        (ld),
        .clr       (clr),
        .shift     (shift),
        .cap       (cap),
        .bit_idx   (bit_idx),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LEN_W-1:0] len;
        int unsigned      hold;
        bit               poke;
        int unsigned      leff;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Output bundle: {in_ready, ld, clr, shift, cap, busy, out_valid, bit_idx}
    function automatic logic [31:0] outs();
        return 32'({in_ready, ld, clr, shift, cap, busy, out_valid, bit_idx});
    endfunction

    function automatic logic [31:0] mk(input bit ir, input bit l, input bit c, input bit sh,
                                       input bit cp, input bit bz, input bit ov,
                                       input logic [CNT_W-1:0] idx);
        return 32'({ir, l, c, sh, cp, bz, ov, idx});
    endfunction

    task automatic start_cmd(input logic [LEN_W-1:0] len);
        @(posedge clk); #1;
        in_valid = 1'b1; op_len = len; abort = 1'b0;
        @(negedge clk);
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; op_len = ~len;
        @(negedge clk);
    endtask

    task automatic run_op(input logic [LEN_W-1:0] len, input int unsigned leff,
                          input int unsigned hold, input bit poke);
        bit e_ld, e_sh, e_cap, e_busy, e_ov, e_ir;
        logic [CNT_W-1:0] e_idx;
        @(posedge clk); #1;
        in_valid = 1'b1; op_len = len; abort = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("accept_ready", 32'(in_ready), 32'd1);
        for (int unsigned c = 1; c <= 3 + 2 * leff + hold; c++) begin
            @(posedge clk); #1;
            in_valid  = poke && (c > 2 * leff + 2) && (c < 2 * leff + 2 + hold);
            op_len    = ~len;
            out_ready = (c >= 2 * leff + 2 + hold);
            @(negedge clk);
            e_ld   = (c == 1);
            e_sh   = (c >= 2) && (c <= 1 + 2 * leff);
            e_cap  = (c == 1 + 2 * leff);
            e_busy = (c <= 1 + 2 * leff);
            e_ov   = (c >= 2 + 2 * leff) && (c <= 2 + 2 * leff + hold);
            e_ir   = (c == 3 + 2 * leff + hold);
            e_idx  = e_sh ? CNT_W'(c - 2) : '0;
            check($sformatf("op len=%0d hold=%0d cycle=%0d", len, hold, c), outs(),
                  mk(e_ir, e_ld, e_ld, e_sh, e_cap, e_busy, e_ov, e_idx));
        end
        in_valid = 1'b0;
    endtask

    task automatic watch_quiet(input string name, input int unsigned cycles);
        int unsigned hits = 0;
        for (int unsigned i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (cap || out_valid || busy) hits++;
        end
        check(name, 32'(hits), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned second;
        int unsigned capc;

        vecs[0] = '{len: 4'd8,  hold: 0, poke: 1'b0, leff: 8};
        vecs[1] = '{len: 4'd3,  hold: 0, poke: 1'b0, leff: 3};
        vecs[2] = '{len: 4'd0,  hold: 0, poke: 1'b0, leff: 8};
        vecs[3] = '{len: 4'd12, hold: 0, poke: 1'b0, leff: 8};
        vecs[4] = '{len: 4'd1,  hold: 0, poke: 1'b0, leff: 1};
        vecs[5] = '{len: 4'd8,  hold: 5, poke: 1'b1, leff: 8};
        vecs[6] = '{len: 4'd5,  hold: 2, poke: 1'b0, leff: 5};

        rst = 1'b1; in_valid = 1'b0; op_len = '0; abort = 1'b0; out_ready = 1'b0;
        #12;
        check("reset_outputs", outs(), mk(1, 0, 0, 0, 0, 0, 0, '0));
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", outs(), mk(1, 0, 0, 0, 0, 0, 0, '0));

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].len, vecs[i].leff, vecs[i].hold, vecs[i].poke);

        // abort in IDLE blocks the accept
        @(posedge clk); #1;
        in_valid = 1'b1; op_len = 4'd3; abort = 1'b1;
        @(negedge clk);
        check("idle_abort_outputs", outs(), mk(0, 0, 0, 0, 0, 0, 0, '0));
        @(posedge clk); #1;
        in_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("idle_abort_no_accept", outs(), mk(1, 0, 0, 0, 0, 0, 0, '0));

        // abort on bit_idx=4 (cycle 6 after accept)
        out_ready = 1'b1;
        start_cmd(4'd8);
        for (int unsigned c = 2; c <= 6; c++) begin
            @(posedge clk); #1;
            abort = (c == 6);
            @(negedge clk);
        end
        check("abort_mul_cycle", outs(), mk(0, 0, 0, 0, 0, 1, 0, 4'd4));
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        check("abort_mul_idle", outs(), mk(1, 0, 0, 0, 0, 0, 0, '0));
        watch_quiet("abort_mul_quiet", 25);
        run_op(4'd8, 8, 0, 1'b0);

        // abort in the cap cycle (L=2, cap at cycle 5)
        out_ready = 1'b1;
        start_cmd(4'd2);
        for (int unsigned c = 2; c <= 5; c++) begin
            @(posedge clk); #1;
            abort = (c == 5);
            @(negedge clk);
        end
        check("abort_cap_cycle", outs(), mk(0, 0, 0, 0, 0, 1, 0, 4'd3));
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        check("abort_cap_idle", outs(), mk(1, 0, 0, 0, 0, 0, 0, '0));
        watch_quiet("abort_cap_quiet", 10);

        // asynchronous reset mid-MUL
        start_cmd(4'd8);
        for (int unsigned c = 2; c <= 8; c++) @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst_outputs", outs(), mk(1, 0, 0, 0, 0, 0, 0, '0));
        #1 rst = 1'b0;
        watch_quiet("async_rst_quiet", 25);
        run_op(4'd3, 3, 0, 1'b0);

        // back-to-back with in_valid held: L=3 then L=2
        out_ready = 1'b1;
        second = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; op_len = 4'd3;
        @(negedge clk);
        check("b2b_first_ready", 32'(in_ready), 32'd1);
        for (int unsigned c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            op_len = 4'd2;
            @(negedge clk);
            if (in_ready && in_valid) begin
                second = c;
                break;
            end
        end
        check("b2b_accept_spacing", 32'(second), 32'd9);
        capc = 0;
        for (int unsigned d = 1; d <= 20; d++) begin
            @(posedge clk); #1;
            in_valid = 1'b0; op_len = 4'd7;
            @(negedge clk);
            if (cap) begin
                capc = d;
                break;
            end
        end
        check("b2b_second_leff", 32'(capc), 32'd5);
        repeat (4) @(negedge clk);
        check("b2b_final_idle", outs(), mk(1, 0, 0, 0, 0, 0, 0, '0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
